ram_port_arbiter: RTL and testbench

Shares the single-port 32K×16 display/data RAM between two requesters: the core data port, which the address decoder routes here whenever Address[23:16] selects RAM, and the video scan-out fetcher. The arbiter picks one winner per cycle and registers the winner's address, write enable and write data onto the RAM port. It then routes the one-cycle-late RAM read data back to the requester that issued the read. Video normally wins, and a starvation counter guarantees the core a slot within a bounded number of cycles.

---
 rtl/ram_port_arbiter.sv | 74 +++++++
 tb/tb_ram_port_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between the core data port and video scan-out.
// Video wins by default; a starvation counter forces a core slot after MAX_WAIT refusals.
module ram_port_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    logic [3:0] r_wait_cnt;
    logic       r_rd_pend;
    logic       r_rd_owner;
    logic       r_ret_pend;
    logic       r_ret_owner;
    logic       w_core_pri;
    logic       w_rd_acc;

    assign w_core_pri = core_req && (r_wait_cnt >= 4'(MAX_WAIT));
    assign core_gnt   = core_req && (w_core_pri || !vid_req);
    assign vid_gnt    = vid_req && !w_core_pri;
    assign w_rd_acc   = vid_gnt || (core_gnt && !core_we);

    // rd_pend/rd_owner track the address edge; ret_* track the edge the RAM output becomes valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt  <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_owner  <= 1'b0;
            r_ret_pend  <= 1'b0;
            r_ret_owner <= 1'b0;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_wdata   <= '0;
            core_rvalid <= 1'b0;
            vid_rvalid  <= 1'b0;
            core_rdata  <= '0;
            vid_rdata   <= '0;
        end else begin
            r_wait_cnt  <= (core_req && !core_gnt) ? ((r_wait_cnt == 4'd15) ? 4'd15 : r_wait_cnt + 4'd1) : 4'd0;
            ram_we      <= core_gnt && core_we;
            if (core_gnt || vid_gnt)
                ram_addr <= vid_gnt ? vid_addr : core_addr;
            if (core_gnt)
                ram_wdata <= core_wdata;
            r_rd_pend   <= w_rd_acc;
            r_rd_owner  <= vid_gnt;
            r_ret_pend  <= r_rd_pend;
            r_ret_owner <= r_rd_owner;
            core_rvalid <= r_ret_pend && !r_ret_owner;
            vid_rvalid  <= r_ret_pend && r_ret_owner;
            if (r_ret_pend && !r_ret_owner)
                core_rdata <= ram_rdata;
            if (r_ret_pend && r_ret_owner)
                vid_rdata <= ram_rdata;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: table vectors, directed corner sequences and random traffic,
// all scored against a transaction-level model of grants, RAM contents and read returns.
module tb_ram_port_arbiter;
    localparam int AW = 15;
    localparam int DW = 16;
    localparam int MW = 4;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          core_req = 0, core_we = 0, vid_req = 0;
    logic [AW-1:0] core_addr = 0, vid_addr = 0;
    logic [DW-1:0] core_wdata = 0;
    logic          core_gnt, core_rvalid, vid_gnt, vid_rvalid, ram_we;
    logic [DW-1:0] core_rdata, vid_rdata, ram_wdata;
    logic [DW-1:0] ram_rdata = 0;
    logic [AW-1:0] ram_addr;
    int            checks = 0, errors = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // synchronous read-first RAM
    logic [DW-1:0] mem [0:32767];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", n, got, exp, $time);
        end
    endtask

    // Reference model: accesses apply to a shadow memory in acceptance order; reads return
    // the shadow value at acceptance two edges later, in issue order.
    typedef struct {logic own; logic [DW-1:0] d; int due;} rd_t;
    rd_t           q[$];
    rd_t           r;
    logic [DW-1:0] shadow [0:32767];
    int            cyc = 0, w = 0;
    logic          e_cv = 0, e_vv = 0, e_we = 0, m_pri, m_cg, m_vg;
    logic [DW-1:0] e_cd = 0, e_vd = 0, e_wd = 0;
    logic [AW-1:0] e_addr = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            w = 0; e_cv = 0; e_vv = 0; e_we = 0; e_cd = 0; e_vd = 0; e_wd = 0; e_addr = 0;
        end else begin
            cyc++;
            m_pri = core_req && w >= MW;
            m_cg  = core_req && (m_pri || !vid_req);
            m_vg  = vid_req && !m_pri;
            e_cv = 0; e_vv = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                r = q.pop_front();
                if (r.own) begin e_vv = 1; e_vd = r.d; end
                else begin e_cv = 1; e_cd = r.d; end
            end
            e_we = m_cg && core_we;
            if (m_cg || m_vg) e_addr = m_vg ? vid_addr : core_addr;
            if (m_cg) e_wd = core_wdata;
            if (m_vg || (m_cg && !core_we))
                q.push_back('{m_vg, shadow[m_vg ? vid_addr : core_addr], cyc + 2});
            if (m_cg && core_we) shadow[core_addr] = core_wdata;
            w = (core_req && !m_cg) ? ((w == 15) ? 15 : w + 1) : 0;
        end
    end

    always @(negedge clk) begin
        chk("sb_core_gnt", core_gnt, core_req && ((core_req && w >= MW) || !vid_req));
        chk("sb_vid_gnt", vid_gnt, vid_req && !(core_req && w >= MW));
        chk("sb_ram_we", ram_we, e_we);
        chk("sb_ram_addr", ram_addr, e_addr);
        if (e_we) chk("sb_ram_wdata", ram_wdata, e_wd);
        chk("sb_core_rvalid", core_rvalid, e_cv);
        chk("sb_vid_rvalid", vid_rvalid, e_vv);
        chk("sb_core_rdata", core_rdata, e_cd);
        chk("sb_vid_rdata", vid_rdata, e_vd);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic core_acc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic ok = 0;
        core_req = 1; core_we = we; core_addr = a; core_wdata = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = core_gnt;
            step();
        end
        core_req = 0;
        chk("core_acc_done", ok, 1);
    endtask

    typedef struct {logic c, we, v, ecg, evg, ewe;} vec_t;
    vec_t tbl[14];

    initial begin
        int n, first, last;
        logic ca, va;
        tbl[0]  = '{1,1,1, 0,1,0};
        tbl[1]  = '{1,1,1, 0,1,0};
        tbl[2]  = '{1,1,1, 0,1,0};
        tbl[3]  = '{1,1,1, 0,1,0};
        tbl[4]  = '{1,1,1, 1,0,0};
        tbl[5]  = '{0,0,1, 0,1,1};
        tbl[6]  = '{1,0,0, 1,0,0};
        tbl[7]  = '{0,0,0, 0,0,0};
        tbl[8]  = '{1,0,1, 0,1,0};
        tbl[9]  = '{1,0,1, 0,1,0};
        tbl[10] = '{1,0,1, 0,1,0};
        tbl[11] = '{1,0,1, 0,1,0};
        tbl[12] = '{1,0,1, 1,0,0};
        tbl[13] = '{0,0,0, 0,0,0};
        for (int i = 0; i < 32768; i++) begin
            shadow[i] = 16'(i * 7 + 3);
            mem[i] <= 16'(i * 7 + 3);
        end
        repeat (2) @(negedge clk);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_core_rvalid", core_rvalid, 0);
        step();
        rst_n = 1;
        step();

        // core write then read with exact latency
        core_acc(1, 15'h0010, 16'hBEEF);
        @(negedge clk);
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_addr", ram_addr, 15'h0010);
        chk("wr_ram_wdata", ram_wdata, 16'hBEEF);
        step();
        core_acc(0, 15'h0010, 16'h0);
        @(negedge clk); chk("rd_lat_e0", core_rvalid, 0);
        step();
        @(negedge clk); chk("rd_lat_e1", core_rvalid, 0);
        step();
        @(negedge clk); chk("rd_lat_e2", core_rvalid, 1); chk("rd_data", core_rdata, 16'hBEEF);
        step();
        @(negedge clk); chk("rd_pulse_end", core_rvalid, 0);
        step();

        // contention / write guard table
        for (int i = 0; i < 14; i++) begin
            core_req = tbl[i].c; core_we = tbl[i].we; vid_req = tbl[i].v;
            core_addr = 15'h0100; core_wdata = 16'h1234; vid_addr = 15'h0200;
            @(negedge clk);
            chk($sformatf("tbl%0d_core_gnt", i), core_gnt, tbl[i].ecg);
            chk($sformatf("tbl%0d_vid_gnt", i), vid_gnt, tbl[i].evg);
            chk($sformatf("tbl%0d_ram_we", i), ram_we, tbl[i].ewe);
            step();
        end
        repeat (4) step();

        // video streaming
        for (int i = 0; i < 8; i++) core_acc(1, 15'(15'h4000 + i), 16'(16'hC000 + i));
        repeat (2) step();
        n = 0; first = -1; last = -1;
        for (int t = 0; t < 14; t++) begin
            vid_req = (t < 8);
            vid_addr = 15'(15'h4000 + t);
            @(negedge clk);
            if (t < 8) chk("stream_gnt", vid_gnt, 1);
            if (vid_rvalid) begin
                chk("stream_data", vid_rdata, 16'(16'hC000 + n));
                if (n == 0) first = t;
                last = t;
                n++;
            end
            step();
        end
        chk("stream_count", n, 8);
        chk("stream_nogap", last - first, 7);

        // interleaved reads
        core_acc(1, 15'h0001, 16'h1111);
        core_acc(1, 15'h0002, 16'h2222);
        step();
        core_req = 1; core_we = 0; core_addr = 15'h0001;
        @(negedge clk); chk("il_core_gnt", core_gnt, 1);
        step();
        core_req = 0; vid_req = 1; vid_addr = 15'h0002;
        @(negedge clk); chk("il_vid_gnt", vid_gnt, 1);
        step();
        vid_req = 0;
        @(negedge clk); chk("il_idle_c", core_rvalid, 0); chk("il_idle_v", vid_rvalid, 0);
        step();
        @(negedge clk);
        chk("il_core_rvalid", core_rvalid, 1); chk("il_core_rdata", core_rdata, 16'h1111);
        chk("il_core_no_cross", vid_rvalid, 0);
        step();
        @(negedge clk);
        chk("il_vid_rvalid", vid_rvalid, 1); chk("il_vid_rdata", vid_rdata, 16'h2222);
        chk("il_vid_no_cross", core_rvalid, 0); chk("il_core_hold", core_rdata, 16'h1111);
        step();

        // reset mid-read
        core_acc(0, 15'h0010, 16'h0);
        #2 rst_n = 0;
        @(negedge clk);
        chk("mrst_core_rdata", core_rdata, 0);
        chk("mrst_vid_rdata", vid_rdata, 0);
        chk("mrst_ram_addr", ram_addr, 0);
        step();
        rst_n = 1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n += int'(core_rvalid) + int'(vid_rvalid);
            step();
        end
        chk("mrst_no_rvalid", n, 0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            ca = core_req && core_gnt;
            va = vid_req && vid_gnt;
            step();
            if (!core_req || ca) begin
                core_req = 1'($urandom_range(0, 1));
                core_we = 1'($urandom_range(0, 1));
                core_addr = 15'($urandom_range(0, 15));
                core_wdata = 16'($urandom);
            end
            if (!vid_req || va) begin
                vid_req = ($urandom_range(0, 3) != 0);
                vid_addr = 15'($urandom_range(0, 15));
            end
        end
        @(negedge clk);
        ca = core_req && core_gnt;
        step();
        for (int i = 0; i < 40 && core_req && !ca; i++) begin
            vid_req = 0;
            @(negedge clk);
            ca = core_gnt;
            step();
        end
        core_req = 0; vid_req = 0;
        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
